serial_frame_tx: RTL and testbench

- Parallel-to-serial frame transmitter; the sending end of the single-wire frame protocol consumed by the serial receiver controller/datapath.
- Frame: start bit (0), port number (PORT_W bits, MSB first), length field (LEN_W bits, MSB first), then `length` data bits (LSB first); the line idles at 1.
- Sits between the host logic, which presents port/len/data with a start strobe, and the serial line SerOut.

---
 rtl/frame_pkg.sv | 26 ++
 rtl/frame_tx_piso.sv | 54 +++++
 rtl/serial_frame_tx.sv | 167 ++++++++++++++++
 tb/tb_serial_frame_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared constants and state encoding for the serial frame protocol
// Used by both the transmitter and the receiver side; no ports.
package frame_pkg;

    localparam int PORT_W  = 2;
    localparam int LEN_W   = 4;
    localparam int DATA_W  = 15;

    // One counter serves both header fields, so it spans the wider of the two.
    localparam int CNT_W   = (PORT_W > LEN_W) ? PORT_W : LEN_W;

    // Everything after the start bit, in the order it leaves the wire.
    localparam int FRAME_W = PORT_W + LEN_W + DATA_W;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        START = 3'b001,
        PORT  = 3'b010,
        LEN   = 3'b011,
        DATA  = 3'b100
    } frame_state_t;

endpackage

// File: rtl/frame_tx_piso.sv
// rtl/frame_tx_piso.sv - loadable right-shift register plus down-counter for the frame transmitter
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   en              bit-rate enable; nothing moves without it
//   load, load_data parallel load of the whole frame image (bit 0 leaves first)
//   shift           advance the register by one bit toward bit 0
//   cnt_load/val    preload the bit counter
//   cnt_dec         decrement the bit counter
//   sbit            bit currently at the output end of the register
//   cnt_zero        counter has reached zero
module frame_tx_piso
    import frame_pkg::*;
#(
    parameter int W  = FRAME_W,
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic          shift,
    input  logic          cnt_load,
    input  logic [CW-1:0] cnt_val,
    input  logic          cnt_dec,
    output logic          sbit,
    output logic          cnt_zero
);

    logic [W-1:0]  sreg;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (en) begin
            if (load) begin
                sreg <= load_data;
            end else if (shift) begin
                sreg <= {1'b0, sreg[W-1:1]};
            end
            if (cnt_load) begin
                cnt <= cnt_val;
            end else if (cnt_dec) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign sbit     = sreg[0];
    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-to-serial frame transmitter (start, port MSB-first, length MSB-first, data LSB-first)
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   clkEn           bit-rate enable; one asserted cycle is one bit period
//   start           frame request, taken only on a tick while idle
//   port_in         destination port number
//   len_in          number of data bits (saturated at DATA_W)
//   data_in         payload, bit 0 sent first
//   SerOut          registered serial line, idles high
//   Busy            high from acceptance until the line returns idle
//   Done            one-clk pulse at frame completion
module serial_frame_tx
    import frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              start,
    input  logic [PORT_W-1:0] port_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              SerOut,
    output logic              Busy,
    output logic              Done
);

    frame_state_t       state, state_nxt;
    logic               ser_nxt, busy_nxt, done_nxt;
    logic [LEN_W-1:0]   len_r, len_sat;
    logic [FRAME_W-1:0] load_word;

    logic               load, shift, cnt_load, cnt_dec;
    logic [CNT_W-1:0]   cnt_val;
    logic               sbit, cnt_zero;

    // Only reachable when DATA_W < 2**LEN_W - 1.
    assign len_sat = ({1'b0, len_in} > (LEN_W+1)'(DATA_W)) ? LEN_W'(DATA_W) : len_in;

    // Frame image in wire order from bit 0: header fields reversed so they
    // leave MSB first, payload unchanged so it leaves LSB first.
    always_comb begin
        load_word = '0;
        for (int i = 0; i < PORT_W; i++) begin
            load_word[i] = port_in[PORT_W-1-i];
        end
        for (int j = 0; j < LEN_W; j++) begin
            load_word[PORT_W+j] = len_sat[LEN_W-1-j];
        end
        load_word[FRAME_W-1:PORT_W+LEN_W] = data_in;
    end

    frame_tx_piso #(
        .W  (FRAME_W),
        .CW (CNT_W)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .en        (clkEn),
        .load      (load),
        .load_data (load_word),
        .shift     (shift),
        .cnt_load  (cnt_load),
        .cnt_val   (cnt_val),
        .cnt_dec   (cnt_dec),
        .sbit      (sbit),
        .cnt_zero  (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            SerOut <= IDLE_LEVEL;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            len_r  <= '0;
        end else begin
            state  <= state_nxt;
            SerOut <= ser_nxt;
            Busy   <= busy_nxt;
            Done   <= done_nxt;
            if (load) begin
                len_r <= len_sat;
            end
        end
    end

    // Every state past START emits the register head and shifts; the counter
    // only decides when a field ends. Done defaults low so it clears on the
    // next clk even when clkEn is low.
    always_comb begin
        state_nxt = state;
        ser_nxt   = SerOut;
        busy_nxt  = Busy;
        done_nxt  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = '0;
        if (clkEn) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        load      = 1'b1;
                        ser_nxt   = START_LEVEL;
                        busy_nxt  = 1'b1;
                        state_nxt = START;
                    end
                end
                START: begin
                    ser_nxt   = sbit;
                    shift     = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(PORT_W-1);
                    state_nxt = PORT;
                end
                PORT: begin
                    ser_nxt = sbit;
                    shift   = 1'b1;
                    if (cnt_zero) begin
                        cnt_load  = 1'b1;
                        cnt_val   = CNT_W'(LEN_W-1);
                        state_nxt = LEN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                LEN: begin
                    if (!cnt_zero) begin
                        ser_nxt = sbit;
                        shift   = 1'b1;
                        cnt_dec = 1'b1;
                    end else if (len_r != '0) begin
                        ser_nxt   = sbit;
                        shift     = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_val   = CNT_W'(len_r) - CNT_W'(1);
                        state_nxt = DATA;
                    end else begin
                        ser_nxt   = IDLE_LEVEL;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                DATA: begin
                    if (!cnt_zero) begin
                        ser_nxt = sbit;
                        shift   = 1'b1;
                        cnt_dec = 1'b1;
                    end else begin
                        ser_nxt   = IDLE_LEVEL;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    ser_nxt   = IDLE_LEVEL;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench for serial_frame_tx
module tb_serial_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        clkEn;
    logic        start;
    logic [1:0]  port_in;
    logic [3:0]  len_in;
    logic [14:0] data_in;
    logic        SerOut, Busy, Done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int period   = 1;
    bit mon_en   = 1'b0;

    // Frame model: the whole frame as a bit queue, consumed one bit per tick.
    bit m_ser  = 1'b1;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit q[$];

    logic [31:0] so_v, mo_v, bz_v, dn_v;

    serial_frame_tx dut (
        .clk     (clk),
        .rst     (rst),
        .clkEn   (clkEn),
        .start   (start),
        .port_in (port_in),
        .len_in  (len_in),
        .data_in (data_in),
        .SerOut  (SerOut),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int l;
        m_done = 1'b0;
        if (!rst) begin
            q.delete();
            m_ser  = 1'b1;
            m_busy = 1'b0;
        end else if (clkEn) begin
            if (!m_busy) begin
                if (start) begin
                    l = (len_in > 15) ? 15 : int'(len_in);
                    q.delete();
                    q.push_back(1'b0);
                    for (int i = 1; i >= 0; i--) q.push_back(port_in[i]);
                    for (int i = 3; i >= 0; i--) q.push_back(len_in[i]);
                    for (int i = 0; i < l; i++)  q.push_back(data_in[i]);
                    m_ser  = q.pop_front();
                    m_busy = 1'b1;
                end
            end else if (q.size() != 0) begin
                m_ser = q.pop_front();
            end else begin
                m_ser  = 1'b1;
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("cyc_ser",  32'(SerOut), 32'(m_ser));
            chk("cyc_busy", 32'(Busy),   32'(m_busy));
            chk("cyc_done", 32'(Done),   32'(m_done));
            if (Done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        for (int i = 0; i < period - 1; i++) begin
            clkEn = 1'b0;
            @(negedge clk);
        end
        clkEn = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        clkEn = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic record(input int k);
        so_v[k] = SerOut;
        mo_v[k] = m_ser;
        bz_v[k] = Busy;
        dn_v[k] = Done;
    endtask

    task automatic run_frame(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d,
                             input int n, input int poke_k);
        so_v = '0; mo_v = '0; bz_v = '0; dn_v = '0;
        port_in = p; len_in = l; data_in = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        record(0);
        for (int k = 1; k < n; k++) begin
            if (k == poke_k) begin
                start   = 1'b1;
                port_in = ~p;
                len_in  = 4'hF;
                data_in = ~d;
            end
            tick();
            start = 1'b0;
            record(k);
        end
    endtask

    initial begin
        int d0;
        rst = 1'b0; clkEn = 1'b1; start = 1'b1;
        port_in = 2'b11; len_in = 4'd5; data_in = 15'h1234;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ser",  32'(SerOut), 32'd1);
        chk("rst_busy", 32'(Busy),   32'd0);
        chk("rst_done", 32'(Done),   32'd0);
        rst = 1'b1;
        idle(3);

        // Nominal frame
        d0 = done_cnt;
        run_frame(2'b10, 4'd3, 15'h0005, 11, -1);
        chk("nom_ser",   so_v[10:0], 32'b11011100010);
        chk("nom_model", mo_v[10:0], 32'b11011100010);
        chk("nom_busy",  bz_v[10:0], 32'b01111111111);
        chk("nom_done",  dn_v[10:0], 32'b10000000000);
        idle(3);
        chk("nom_dcnt", 32'(done_cnt - d0), 32'd1);

        // Zero length
        run_frame(2'b01, 4'd0, 15'h7FFF, 8, -1);
        chk("zero_ser",  so_v[7:0], 32'b10000100);
        chk("zero_busy", bz_v[7:0], 32'b01111111);
        chk("zero_done", dn_v[7:0], 32'b10000000);
        idle(3);

        // Full length
        run_frame(2'b11, 4'd15, 15'h7FFF, 23, -1);
        chk("full_ser",  so_v[22:0], 32'h7FFFFE);
        chk("full_busy", bz_v[22:0], 32'h3FFFFF);
        chk("full_done", dn_v[22:0], 32'h400000);
        idle(3);

        // Slow enable
        period = 4;
        d0 = done_cnt;
        run_frame(2'b10, 4'd3, 15'h0005, 11, -1);
        chk("slow_ser",  so_v[10:0], 32'b11011100010);
        chk("slow_busy", bz_v[10:0], 32'b01111111111);
        idle(3);
        chk("slow_dcnt", 32'(done_cnt - d0), 32'd1);
        period = 1;

        // Inputs changed and start pulsed during DATA
        run_frame(2'b10, 4'd3, 15'h0005, 11, 8);
        chk("ign_ser",  so_v[10:0], 32'b11011100010);
        chk("ign_done", dn_v[10:0], 32'b10000000000);
        idle(3);
        chk("ign_quiet", 32'(Busy), 32'd0);

        // start held high: one idle bit between frames
        port_in = 2'b10; len_in = 4'd3; data_in = 15'h0005;
        start = 1'b1;
        repeat (11) tick();
        chk("hold_gap_ser",  32'(SerOut), 32'd1);
        chk("hold_gap_done", 32'(Done),   32'd1);
        tick();
        chk("hold_next_ser",  32'(SerOut), 32'd0);
        chk("hold_next_busy", 32'(Busy),   32'd1);
        start = 1'b0;
        repeat (10) tick();
        chk("hold_end_busy", 32'(Busy), 32'd0);
        idle(3);

        // Abort during the second data bit
        d0 = done_cnt;
        run_frame(2'b10, 4'd3, 15'h0005, 9, -1);
        chk("abort_pre", 32'(SerOut), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_ser",  32'(SerOut), 32'd1);
        chk("abort_busy", 32'(Busy),   32'd0);
        chk("abort_done", 32'(Done),   32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_ser",  32'(SerOut), 32'd0);
        chk("restart_busy", 32'(Busy),   32'd1);
        repeat (10) tick();
        idle(3);
        chk("abort_dcnt", 32'(done_cnt - d0), 32'd1);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
